microsequencer: RTL
===================

# microsequencer

Next-state controller for the microprogrammed control unit. Each cycle it takes the sequencing fields of the current microinstruction from the microstore, the decoded-opcode entry state and the datapath condition bits, and computes the 10-bit state the microstore reads next. It holds the control-unit state register, a 4-entry microsubroutine return stack and a wait watchdog for memory handshakes.

## Interface
- `DEPTH`, 4: return-stack entries.
- `WAIT_LIMIT`, 255: maximum consecutive WAIT cycles before a fault.
- `FAULT_STATE`, 10'd1023: state entered on a watchdog timeout or stack underflow.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; asserted at 0.
- `stall`  in  1  holds all state when 1.
- `mode`  in  3  sequencing mode field of the current microinstruction.
- `cr_addr`  in  10  branch/jump target field.
- `cond_sel`  in  3  selects one bit of `cond_in`.
- `inv`  in  1  inverts the selected condition.
- `cond_in`  in  8  condition bits; bit 0 is MOC (memory operation complete).
- `decoded_state`  in  10  entry state from the instruction encoder.
- `next_state`  out  10  registered state address driven to the microstore.
- `depth`  out  3  current stack occupancy.
- `stack_err`  out  1  sticky overflow/underflow flag.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- `c = cond_in[cond_sel] ^ inv`. `inc = next_state + 1`, taken modulo 1024 (1023 wraps to 0).
- Mode decodes:
  - 0 INC: go to `inc`.
  - 1 JUMP: go to `cr_addr`.
  - 2 DECODE: go to `decoded_state`.
  - 3 BRANCH: go to `c ? cr_addr : inc`.
  - 4 WAIT: go to `c ? inc : next_state`.
  - 5 CALL: push `inc`, then go to `cr_addr`.
  - 6 RET: pop the top entry and go to it.
  - 7 RESTART: go to 0 and set `depth` to 0. `stack_err` and `timeout` are left unchanged.
- CALL with `depth == DEPTH`: no push, still go to `cr_addr`, set `stack_err`.
- RET with `depth == 0`: go to `FAULT_STATE`, set `stack_err`.
- Watchdog (`wcnt`, 8 bits):
  - In WAIT with `c == 0`, `wcnt` increments.
  - When `wcnt == WAIT_LIMIT` and `c == 0`, go to `FAULT_STATE`, set `timeout`, clear `wcnt`.
  - `wcnt` clears on any cycle that is not a stalled-in-WAIT cycle.
- `stall == 1` freezes `next_state`, the stack, `depth` and `wcnt`. Stall has priority over every mode.

## Timing
- One microinstruction per cycle. The microstore output is combinational from `next_state`, so the sequencer's inputs settle within the same cycle. The new `next_state` registers on the rising `clk` edge.
- Every decision takes effect at the next edge; no multi-cycle paths.
- Reset, asynchronous, effective immediately on assertion:
  - `next_state = 0`, `depth = 0`, `stack_err = 0`, `timeout = 0`, `wcnt = 0`.
  - Stack contents are don't-care.
- Reset asserted mid-WAIT or mid-subroutine abandons all sequencing state. The first edge after deassertion evaluates the state-0 microinstruction.
- Push and pop are single-cycle.
- Sticky flags clear only on reset.

## Structure
- Shared package `ucode_pkg` holds:
  - Mode encodings `M_INC`…`M_RESTART`.
  - `STATE_W = 10`.
  - `COND_W = 8`.
  - `MOC_BIT = 0`.
  - The same package also serves the microstore and encoder.
- Sub-module `ustack`: parameterised LIFO with `push`, `pop`, `din`, `dout` (the top entry, combinational), `depth`, `full` and `empty`. It has no error logic; the sequencer owns the error policy.
- Top level:
  - Condition mux.
  - Next-state mux.
  - Watchdog counter.
  - Flag registers.

## Test plan
- Reset held low, then released; INC runs for 3 cycles: `next_state` reads 0, 1, 2, 3. Then RESTART returns it to 0.
- BRANCH with `cr_addr = 10'h0EF`, `cond_sel = 0`, `inv = 0`:
  - With MOC = 1, `next_state` goes to 0x0EF.
  - With MOC = 0 from state 0x0EF, it goes to 0x0F0.
  - With `inv = 1`, the two outcomes swap.
- WAIT at state 0x01F:
  - MOC low for 5 cycles, then high: `next_state` holds at 0x01F for 5 cycles, then goes to 0x020. `timeout` stays 0.
  - MOC low for 256 cycles: `next_state` goes to 1023 and `timeout` = 1.
- Stack: five CALLs to 0x100, each issued from state 0x100:
  - After the fourth CALL, `depth` = 4 and `stack_err` = 0.
  - The fifth CALL sets `stack_err` = 1 with `depth` still 4.
  - Four RETs return 0x101 four times.
  - A further RET goes to 1023.
- DECODE with `decoded_state = 10'h0CD` and `stall` pulsed high for 2 cycles: `next_state` is unchanged during the stall, then goes to 0x0CD.
- Asynchronous reset asserted mid-WAIT with `depth` = 2:
  - All outputs read 0 before the next `clk` edge.
  - Normal INC sequencing resumes from 0 after release.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared microcode definitions: sequencing modes and field widths.
// Used by the sequencer, the microstore and the instruction encoder.
package ucode_pkg;

  localparam int STATE_W = 10;
  localparam int COND_W  = 8;
  localparam int MOC_BIT = 0;

  typedef enum logic [2:0] {
    M_INC     = 3'd0,
    M_JUMP    = 3'd1,
    M_DECODE  = 3'd2,
    M_BRANCH  = 3'd3,
    M_WAIT    = 3'd4,
    M_CALL    = 3'd5,
    M_RET     = 3'd6,
    M_RESTART = 3'd7
  } mode_e;

  // Sequential successor; 1023 wraps to 0.
  function automatic logic [STATE_W-1:0] inc_state(
    input logic [STATE_W-1:0] s
  );
    return s + STATE_W'(1);
  endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Microstore <-> sequencer bundle: sequencing fields in,
// state address and status out.
interface microsequencer_if;
  import ucode_pkg::*;

  logic               stall;
  logic [2:0]         mode;
  logic [STATE_W-1:0] cr_addr;
  logic [2:0]         cond_sel;
  logic               inv;
  logic [COND_W-1:0]  cond_in;
  logic [STATE_W-1:0] decoded_state;
  logic [STATE_W-1:0] next_state;
  logic [2:0]         depth;
  logic               stack_err;
  logic               timeout;

  modport master (
    output stall, mode, cr_addr, cond_sel, inv,
    output cond_in, decoded_state,
    input  next_state, depth, stack_err, timeout
  );

  modport slave (
    input  stall, mode, cr_addr, cond_sel, inv,
    input  cond_in, decoded_state,
    output next_state, depth, stack_err, timeout
  );

endinterface

// File: rtl/microsequencer_ustack.sv
// Microsubroutine return-address LIFO; top entry is combinational.
// No error policy here: overflowing pushes and empty pops are ignored.
module ustack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] depth_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign wr_idx  = IW'(depth_q);
  assign top_idx = IW'(depth_q - DW'(1));
  assign dout    = mem[top_idx];
  assign depth   = depth_q;

  // Occupancy counter; restart empties the stack in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
    end else if (clr) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + DW'(1);
    end else if (do_pop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Next-state controller for the microprogrammed control unit:
// condition mux, next-state mux, return stack and WAIT watchdog.
module microsequencer
  import ucode_pkg::*;
#(
  parameter int                 DEPTH       = 4,
  parameter int                 WAIT_LIMIT  = 255,
  parameter logic [STATE_W-1:0] FAULT_STATE = 10'd1023
) (
  input logic           clk,
  input logic           reset,
  microsequencer_if.slave bus
);

  localparam int DW = $clog2(DEPTH + 1);

  mode_e              mode;
  logic               c;
  logic [STATE_W-1:0] ns_q;
  logic [STATE_W-1:0] ns_d;
  logic [STATE_W-1:0] ns_inc;
  logic               serr_q;
  logic               serr_d;
  logic               to_q;
  logic               to_d;
  logic [7:0]         wcnt_q;
  logic [7:0]         wcnt_d;
  logic               push;
  logic               pop;
  logic               clr;
  logic [STATE_W-1:0] top;
  logic [DW-1:0]      stk_depth;
  logic               full;
  logic               empty;

  assign mode   = mode_e'(bus.mode);
  assign c      = bus.cond_in[bus.cond_sel] ^ bus.inv;
  assign ns_inc = inc_state(ns_q);

  ustack #(
    .DEPTH (DEPTH),
    .W     (STATE_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   (ns_inc),
    .dout  (top),
    .depth (stk_depth),
    .full  (full),
    .empty (empty)
  );

  // Next-state, stack-control, watchdog and flag decisions.
  always_comb begin
    ns_d   = ns_q;
    serr_d = serr_q;
    to_d   = to_q;
    wcnt_d = wcnt_q;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    if (!bus.stall) begin
      wcnt_d = '0;
      unique case (mode)
        M_INC:    ns_d = ns_inc;
        M_JUMP:   ns_d = bus.cr_addr;
        M_DECODE: ns_d = bus.decoded_state;
        M_BRANCH: ns_d = c ? bus.cr_addr : ns_inc;
        M_WAIT: begin
          if (c) begin
            ns_d = ns_inc;
          end else if (wcnt_q == 8'(WAIT_LIMIT)) begin
            ns_d = FAULT_STATE;
            to_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        M_CALL: begin
          ns_d = bus.cr_addr;
          if (full) serr_d = 1'b1;
          else      push   = 1'b1;
        end
        M_RET: begin
          if (empty) begin
            ns_d   = FAULT_STATE;
            serr_d = 1'b1;
          end else begin
            ns_d = top;
            pop  = 1'b1;
          end
        end
        M_RESTART: begin
          ns_d = '0;
          clr  = 1'b1;
        end
      endcase
    end
  end

  // Control-unit state, sticky flags and watchdog count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ns_q   <= '0;
      serr_q <= 1'b0;
      to_q   <= 1'b0;
      wcnt_q <= '0;
    end else begin
      ns_q   <= ns_d;
      serr_q <= serr_d;
      to_q   <= to_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign bus.next_state = ns_q;
  assign bus.depth      = 3'(stk_depth);
  assign bus.stack_err  = serr_q;
  assign bus.timeout    = to_q;

endmodule
